router_fsm: RTL and testbench
=============================

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have no parameters; state encoding is internal (3-bit).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 pkt_valid  input  1  source drives header/payload; deasserts with the parity byte.
REQ-005 data_in  input  2  header address field (data_in[1:0]); 3 is invalid.
REQ-006 fifo_full  input  1  addressed output FIFO full.
REQ-007 fifo_empty_0 / fifo_empty_1 / fifo_empty_2  input  1 each  per-port FIFO empty.
REQ-008 soft_reset_0 / soft_reset_1 / soft_reset_2  input  1 each  per-port timeout soft reset.
REQ-009 parity_done  input  1  register block has captured the parity byte.
REQ-010 low_pkt_valid  input  1  register block saw pkt_valid low while full.
REQ-011 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  output  1 each  control strobes to register block.
REQ-012 write_enb_reg  output  1  FIFO write enable.
REQ-013 busy  output  1  stall request to packet source.

Function
REQ-014 SHALL implement a Moore FSM with states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-015 SHALL latch data_in into a 2-bit addr register on any clock in DECODE_ADDRESS with pkt_valid=1.
REQ-016 DECODE_ADDRESS: pkt_valid=1, data_in=k (k in 0..2), fifo_empty_k=1 -> LOAD_FIRST_DATA; fifo_empty_k=0 -> WAIT_TILL_EMPTY; data_in=3 or pkt_valid=0 -> stay.
REQ-017 LOAD_FIRST_DATA -> LOAD_DATA unconditionally (one cycle).
REQ-018 LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE (priority); else pkt_valid=0 -> LOAD_PARITY; else stay.
REQ-019 FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-020 LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else -> LOAD_DATA.
REQ-021 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-022 CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-023 WAIT_TILL_EMPTY: fifo_empty_addr=1 (selected by latched addr) -> LOAD_FIRST_DATA; else stay.
REQ-024 soft_reset_addr=1 (latched addr) SHALL force next state DECODE_ADDRESS from any state, overriding REQ-016..023; soft resets of other ports SHALL be ignored.
REQ-025 Outputs decoded from current state only: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
REQ-026 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; 0 otherwise.
REQ-027 busy SHALL be 0 in DECODE_ADDRESS and LOAD_DATA; 1 in all other states.
REQ-028 Exactly one of the six strobes in REQ-025 SHALL be high, except in LOAD_PARITY and WAIT_TILL_EMPTY where all six are 0.
REQ-029 Output latency: strobes change one clock after the qualifying input condition is sampled.

Reset
REQ-030 resetn=0 SHALL immediately (no clock) force state=DECODE_ADDRESS, addr=0.
REQ-031 During/after reset: detect_add=1; lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; first post-reset edge evaluates DECODE_ADDRESS rules.

Verification
REQ-033 Good packet, addr 2, fifo_empty_2=1, 14 payload bytes, no full -> states DECODE, LFD(1 cycle), LOAD_DATA x14, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE; rst_int_reg high exactly 1 cycle; write_enb_reg high 15 cycles.
REQ-034 Header addr 1, fifo_empty_1=0 for 5 cycles -> WAIT_TILL_EMPTY, busy=1 for 5 cycles, then LOAD_FIRST_DATA.
REQ-035 fifo_full=1 mid-payload for 3 cycles, pkt_valid still 1 -> full_state=1 three cycles, busy=1, then laf_state one cycle, back to LOAD_DATA.
REQ-036 fifo_full in LOAD_DATA, released with low_pkt_valid=1, parity_done=0 -> LOAD_AFTER_FULL then LOAD_PARITY; repeat with parity_done=1 -> DECODE_ADDRESS directly.
REQ-037 soft_reset_0=1 while packet targets port 0 in WAIT_TILL_EMPTY -> DECODE next cycle; soft_reset_1 pulse during same packet -> no effect.
REQ-038 Header data_in=3 with pkt_valid=1 -> remains DECODE_ADDRESS, detect_add=1, write_enb_reg=0; async resetn pulse mid-LOAD_DATA -> detect_add=1 before next edge.

Source files
------------

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences payload/parity
// loading into the addressed output FIFO and stalls the source when needed.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  // state              | meaning
  // S_DECODE_ADDRESS   | idle, waiting for a header with a valid address
  // S_LOAD_FIRST_DATA  | header byte written to the addressed FIFO
  // S_LOAD_DATA        | streaming payload bytes
  // S_FIFO_FULL        | destination FIFO full, source stalled
  // S_LOAD_AFTER_FULL  | write of the byte held while the FIFO was full
  // S_LOAD_PARITY      | writing the parity byte
  // S_CHECK_PARITY     | parity compare strobe to the register block
  // S_WAIT_TILL_EMPTY  | addressed FIFO still draining a previous packet
  typedef enum logic [2:0] {
    S_DECODE_ADDRESS  = 3'd0,
    S_LOAD_FIRST_DATA = 3'd1,
    S_LOAD_DATA       = 3'd2,
    S_FIFO_FULL       = 3'd3,
    S_LOAD_AFTER_FULL = 3'd4,
    S_LOAD_PARITY     = 3'd5,
    S_CHECK_PARITY    = 3'd6,
    S_WAIT_TILL_EMPTY = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic       w_empty_hdr;
  logic       w_empty_sel;
  logic       w_soft_sel;

  // w_empty_hdr looks at the incoming header, the other two at the latched port
  always_comb begin
    w_empty_hdr = 1'b0;
    w_empty_sel = 1'b0;
    w_soft_sel  = 1'b0;
    case (data_in)
      2'd0:    w_empty_hdr = fifo_empty_0;
      2'd1:    w_empty_hdr = fifo_empty_1;
      2'd2:    w_empty_hdr = fifo_empty_2;
      default: w_empty_hdr = 1'b0;
    endcase
    case (r_addr)
      2'd0: begin w_empty_sel = fifo_empty_0; w_soft_sel = soft_reset_0; end
      2'd1: begin w_empty_sel = fifo_empty_1; w_soft_sel = soft_reset_1; end
      2'd2: begin w_empty_sel = fifo_empty_2; w_soft_sel = soft_reset_2; end
      default: begin w_empty_sel = 1'b0; w_soft_sel = 1'b0; end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_DECODE_ADDRESS;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE_ADDRESS && pkt_valid)
        r_addr <= data_in;
    end
  end

  always_comb begin
    w_next        = r_state;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;

    case (r_state)
      S_DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
        if (pkt_valid && data_in != 2'd3)
          w_next = w_empty_hdr ? S_LOAD_FIRST_DATA : S_WAIT_TILL_EMPTY;
      end
      S_LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        w_next    = S_LOAD_DATA;
      end
      S_LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
        if (fifo_full)       w_next = S_FIFO_FULL;
        else if (!pkt_valid) w_next = S_LOAD_PARITY;
      end
      S_FIFO_FULL: begin
        full_state = 1'b1;
        if (!fifo_full) w_next = S_LOAD_AFTER_FULL;
      end
      S_LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        if (parity_done)        w_next = S_DECODE_ADDRESS;
        else if (low_pkt_valid) w_next = S_LOAD_PARITY;
        else                    w_next = S_LOAD_DATA;
      end
      S_LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        w_next        = S_CHECK_PARITY;
      end
      S_CHECK_PARITY: begin
        rst_int_reg = 1'b1;
        w_next      = fifo_full ? S_FIFO_FULL : S_DECODE_ADDRESS;
      end
      S_WAIT_TILL_EMPTY: begin
        if (w_empty_sel) w_next = S_LOAD_FIRST_DATA;
      end
      default: w_next = S_DECODE_ADDRESS;
    endcase

    // a timeout on the port currently owned by this packet abandons it
    if (w_soft_sel)
      w_next = S_DECODE_ADDRESS;
  end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed packet scenarios plus random
// stimulus compared against a rule-level reference model.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int S_DEC = 0, S_LFD = 1, S_LD = 2, S_FULL = 3,
                 S_LAF = 4, S_LP = 5, S_CPE = 6, S_WTE = 7;

  int m_state;
  int m_addr;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  function automatic logic [7:0] exp_out(input int s);
    case (s)
      S_DEC:   return 8'b1000_0000;
      S_LFD:   return 8'b0100_0001;
      S_LD:    return 8'b0010_0010;
      S_FULL:  return 8'b0000_1001;
      S_LAF:   return 8'b0001_0011;
      S_LP:    return 8'b0000_0011;
      S_CPE:   return 8'b0000_0101;
      default: return 8'b0000_0001;
    endcase
  endfunction

  function automatic logic [7:0] obs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            rst_int_reg, write_enb_reg, busy};
  endfunction

  task automatic model_reset();
    m_state = S_DEC;
    m_addr  = 0;
  endtask

  task automatic model_step();
    logic [2:0] emp;
    logic [2:0] srs;
    logic       sr;
    int         hdr;
    int         nxt;
    if (!resetn) begin
      model_reset();
      return;
    end
    emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    srs = {soft_reset_2, soft_reset_1, soft_reset_0};
    hdr = int'(data_in);
    sr  = (m_addr < 3) ? srs[m_addr] : 1'b0;
    nxt = m_state;
    case (m_state)
      S_DEC:  if (pkt_valid && hdr < 3) nxt = emp[hdr] ? S_LFD : S_WTE;
      S_LFD:  nxt = S_LD;
      S_LD:   if (fifo_full) nxt = S_FULL; else if (!pkt_valid) nxt = S_LP;
      S_FULL: if (!fifo_full) nxt = S_LAF;
      S_LAF:  nxt = parity_done ? S_DEC : (low_pkt_valid ? S_LP : S_LD);
      S_LP:   nxt = S_CPE;
      S_CPE:  nxt = fifo_full ? S_FULL : S_DEC;
      default: if (m_addr < 3 && emp[m_addr]) nxt = S_LFD;
    endcase
    if (sr) nxt = S_DEC;
    if (m_state == S_DEC && pkt_valid) m_addr = hdr;
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; fifo_full = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    parity_done = 0; low_pkt_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    model_reset();
    #2;
    n_checks++;
    if (obs() !== exp_out(S_DEC))
      $display("FAIL reset_outputs: got %b want %b", obs(), exp_out(S_DEC));
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (obs() !== exp_out(S_DEC))
      $display("FAIL reset_hold: got %b want %b", obs(), exp_out(S_DEC));
    else n_pass++;
    resetn = 1;
    tick();
  endtask

  task automatic test_good_packet();
    int ld_c = 0, wen_c = 0, rst_c = 0;
    idle_inputs();
    pkt_valid = 1; data_in = 2;
    tick();
    n_checks++;
    if (obs() !== exp_out(S_LFD))
      $display("FAIL gp_lfd: got %b want %b", obs(), exp_out(S_LFD));
    else n_pass++;
    for (int i = 0; i < 17; i++) begin
      if (i == 14) pkt_valid = 0;
      tick();
      ld_c  += int'(ld_state);
      wen_c += int'(write_enb_reg);
      rst_c += int'(rst_int_reg);
    end
    n_checks++;
    if (obs() !== exp_out(S_DEC))
      $display("FAIL gp_end_decode: got %b want %b", obs(), exp_out(S_DEC));
    else n_pass++;
    n_checks++;
    if (ld_c != 14) $display("FAIL gp_ld_cycles: got %0d want 14", ld_c); else n_pass++;
    n_checks++;
    if (wen_c != 15) $display("FAIL gp_wen_cycles: got %0d want 15", wen_c); else n_pass++;
    n_checks++;
    if (rst_c != 1) $display("FAIL gp_rst_int_cycles: got %0d want 1", rst_c); else n_pass++;
  endtask

  task automatic test_wait_empty();
    int wte_c = 0;
    idle_inputs();
    fifo_empty_1 = 0; pkt_valid = 1; data_in = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (obs() === exp_out(S_WTE)) wte_c++;
    end
    fifo_empty_1 = 1;
    tick();
    n_checks++;
    if (wte_c != 5) $display("FAIL we_busy_cycles: got %0d want 5", wte_c); else n_pass++;
    n_checks++;
    if (obs() !== exp_out(S_LFD))
      $display("FAIL we_to_lfd: got %b want %b", obs(), exp_out(S_LFD));
    else n_pass++;
    pkt_valid = 0;
    repeat (4) tick();
    n_checks++;
    if (obs() !== exp_out(S_DEC))
      $display("FAIL we_end_decode: got %b want %b", obs(), exp_out(S_DEC));
    else n_pass++;
  endtask

  task automatic test_full();
    int full_c = 0;
    idle_inputs();
    pkt_valid = 1; data_in = 0;
    repeat (3) tick();
    fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs() === exp_out(S_FULL)) full_c++;
    end
    fifo_full = 0;
    tick();
    n_checks++;
    if (full_c != 3) $display("FAIL fu_full_cycles: got %0d want 3", full_c); else n_pass++;
    n_checks++;
    if (obs() !== exp_out(S_LAF))
      $display("FAIL fu_laf: got %b want %b", obs(), exp_out(S_LAF));
    else n_pass++;
    tick();
    n_checks++;
    if (obs() !== exp_out(S_LD))
      $display("FAIL fu_back_to_ld: got %b want %b", obs(), exp_out(S_LD));
    else n_pass++;
    pkt_valid = 0;
    repeat (3) tick();
  endtask

  task automatic test_low_pkt();
    for (int rep = 0; rep < 2; rep++) begin
      idle_inputs();
      pkt_valid = 1; data_in = 0;
      repeat (2) tick();
      fifo_full = 1; pkt_valid = 0;
      tick();
      fifo_full = 0; low_pkt_valid = 1; parity_done = (rep == 1);
      tick();
      n_checks++;
      if (obs() !== exp_out(S_LAF))
        $display("FAIL lp_laf_%0d: got %b want %b", rep, obs(), exp_out(S_LAF));
      else n_pass++;
      tick();
      n_checks++;
      if (obs() !== exp_out(rep == 1 ? S_DEC : S_LP))
        $display("FAIL lp_after_laf_%0d: got %b want %b", rep, obs(),
                 exp_out(rep == 1 ? S_DEC : S_LP));
      else n_pass++;
      idle_inputs();
      repeat (2) tick();
    end
  endtask

  task automatic test_soft_reset();
    idle_inputs();
    fifo_empty_0 = 0; pkt_valid = 1; data_in = 0;
    tick();
    pkt_valid = 0; soft_reset_1 = 1;
    tick();
    n_checks++;
    if (obs() !== exp_out(S_WTE))
      $display("FAIL sr_other_port_ignored: got %b want %b", obs(), exp_out(S_WTE));
    else n_pass++;
    soft_reset_1 = 0; soft_reset_0 = 1;
    tick();
    n_checks++;
    if (obs() !== exp_out(S_DEC))
      $display("FAIL sr_own_port: got %b want %b", obs(), exp_out(S_DEC));
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_invalid_addr();
    idle_inputs();
    pkt_valid = 1; data_in = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs() !== exp_out(S_DEC))
        $display("FAIL inv_addr_stay_%0d: got %b want %b", i, obs(), exp_out(S_DEC));
      else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset_mid();
    idle_inputs();
    pkt_valid = 1; data_in = 2;
    repeat (3) tick();
    resetn = 0;
    model_reset();
    #2;
    n_checks++;
    if (obs() !== exp_out(S_DEC))
      $display("FAIL ar_immediate: got %b want %b", obs(), exp_out(S_DEC));
    else n_pass++;
    resetn = 1; pkt_valid = 0;
    tick();
    n_checks++;
    if (obs() !== exp_out(S_DEC))
      $display("FAIL ar_post_edge: got %b want %b", obs(), exp_out(S_DEC));
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 4000; i++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty_0  = ($urandom_range(0, 2) != 0);
      fifo_empty_1  = ($urandom_range(0, 2) != 0);
      fifo_empty_2  = ($urandom_range(0, 2) != 0);
      soft_reset_0  = ($urandom_range(0, 40) == 0);
      soft_reset_1  = ($urandom_range(0, 40) == 0);
      soft_reset_2  = ($urandom_range(0, 40) == 0);
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 1) == 1);
      resetn        = ($urandom_range(0, 300) != 0);
      if (!resetn) begin
        model_reset();
        #1;
        n_checks++;
        if (obs() !== exp_out(S_DEC)) begin
          if (errs < 10)
            $display("FAIL rnd_async_reset cyc %0d: got %b want %b", i, obs(), exp_out(S_DEC));
          errs++;
        end else n_pass++;
      end
      tick();
      n_checks++;
      if (obs() !== exp_out(m_state)) begin
        if (errs < 10)
          $display("FAIL rnd_cycle %0d: got %b want %b", i, obs(), exp_out(m_state));
        errs++;
      end else n_pass++;
    end
    resetn = 1;
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_wait_empty();
    test_full();
    test_low_pkt();
    test_soft_reset();
    test_invalid_addr();
    test_async_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
